if_sequencer: RTL and testbench

Instruction fetch sequencer for the base core. It reads the three bytes of each 24-bit instruction from the 8-bit memory port using a req/ack handshake, and assembles them into the instruction word. It presents that word to the decode stage and holds it until decode reports the instruction finished. It then reloads its program counter from decode's next-address output, so jumps, interrupt vectoring (address 0) and the normal +3 step all follow decode's choice.

---
 rtl/if_sequencer.sv | 50 +++++
 tb/tb_if_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_sequencer.sv
// if_sequencer: fetches 24-bit instructions byte by byte and holds them for decode
module if_sequencer #(
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [23:0] instruction,
  output logic        instr_valid,
  output logic [15:0] current_instruction_address,
  input  logic        instruction_finished,
  input  logic [15:0] next_instruction_address
);
  typedef enum logic [1:0] {FETCH0, FETCH1, FETCH2, ISSUE} state_t;
  state_t state, state_next;
  logic [15:0] pc;
  logic [1:0] off;
  logic take;
  assign off = state == FETCH1 ? 2'd1 : state == FETCH2 ? 2'd2 : 2'd0;
  assign mem_addr = pc + {14'b0, off};
  assign mem_req = !rst && (state == FETCH1 || state == FETCH2 || (state == FETCH0 && !halt));
  assign take = mem_req && mem_ack;
  assign instr_valid = state == ISSUE;
  assign current_instruction_address = pc;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= FETCH0;
    else state <= state_next;
  // advance one fetch state per accepted byte, leave ISSUE on retire
  always_comb begin
    state_next = state;
    if (state == ISSUE) state_next = instruction_finished ? FETCH0 : ISSUE;
    else if (take) state_next = state == FETCH0 ? FETCH1 : state == FETCH1 ? FETCH2 : ISSUE;
  end
  // byte capture into the instruction word and pc reload on retire
  always_ff @(posedge clk)
    if (rst) begin
      pc <= RESET_ADDR;
      instruction <= 24'h000000;
    end else begin
      if (take && state == FETCH0) instruction[23:16] <= mem_data;
      if (take && state == FETCH1) instruction[15:8] <= mem_data;
      if (take && state == FETCH2) instruction[7:0] <= mem_data;
      if (state == ISSUE && instruction_finished) pc <= next_instruction_address;
    end
endmodule

// File: tb/tb_if_sequencer.sv
// tb_if_sequencer: randomized self-checking bench against a transaction-level fetch model
module tb_if_sequencer;
  logic clk, rst, halt, mem_req, mem_ack, instr_valid, fin;
  logic [15:0] mem_addr, cia, next;
  logic [7:0] mem_data;
  logic [23:0] instruction;
  logic [7:0] mem [65536];
  logic [15:0] acked [$];
  logic [15:0] exp_pc;
  int wcfg [3];
  int waited, mid_cnt, total, passed;

  if_sequencer #(.RESET_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .halt(halt), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instruction(instruction),
    .instr_valid(instr_valid), .current_instruction_address(cia),
    .instruction_finished(fin), .next_instruction_address(next)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [23:0] exp_word(input logic [15:0] p);
    logic [15:0] p1, p2;
    p1 = p + 16'd1;
    p2 = p + 16'd2;
    return {mem[p], mem[p1], mem[p2]};
  endfunction

  task automatic tick();
    int o;
    #1;
    o = int'(mem_addr - cia);
    if (o > 2) o = 0;
    mem_ack = mem_req ? (waited >= wcfg[o]) : 1'($urandom % 2);
    mem_data = (mem_req && mem_ack) ? mem[mem_addr] : 8'($urandom);
    if (mem_req && o == 1) mid_cnt++;
    if (mem_req && mem_ack) begin
      acked.push_back(mem_addr);
      waited = 0;
    end else if (mem_req) waited++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] nxt, input int hold, output int cyc,
                           output bit stable, output bit to, output logic [23:0] ins,
                           output logic [15:0] ia);
    cyc = 0;
    while (!instr_valid && cyc < 300) begin
      fin = 1'($urandom % 2);
      next = 16'($urandom);
      tick();
      cyc++;
    end
    to = !instr_valid;
    ins = instruction;
    ia = cia;
    fin = 0;
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (instruction !== ins || mem_req !== 1'b0 || instr_valid !== 1'b1 || cia !== ia) stable = 0;
    end
    fin = 1;
    next = nxt;
    tick();
    fin = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    waited = 0;
    tick();
    tick();
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", instr_valid); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", mem_req); else passed++;
    total++; if (instruction !== 24'h0) $display("FAIL reset_instr got %h exp 000000", instruction); else passed++;
    total++; if (mem_addr !== 16'h0 || cia !== 16'h0) $display("FAIL reset_addr got %h/%h exp 0000", mem_addr, cia); else passed++;
  endtask

  task automatic test_zero_wait();
    mem[0] = 8'h80; mem[1] = 8'h12; mem[2] = 8'h34;
    wcfg = '{0, 0, 0};
    rst = 0;
    #1;
    total++; if (mem_req !== 1'b1) $display("FAIL first_req got %b exp 1", mem_req); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_addr !== 16'(i) || mem_req !== 1'b1) $display("FAIL zw_addr%0d got %h req %b exp %h", i, mem_addr, mem_req, i); else passed++;
      tick();
    end
    total++; if (instr_valid !== 1'b1) $display("FAIL zw_valid got %b exp 1", instr_valid); else passed++;
    total++; if (instruction !== 24'h801234) $display("FAIL zw_instr got %h exp 801234", instruction); else passed++;
    total++; if (cia !== 16'h0000) $display("FAIL zw_cia got %h exp 0000", cia); else passed++;
    fin = 1; next = 16'h0003;
    tick();
    fin = 0;
    total++; if (mem_addr !== 16'h0003 || instr_valid !== 1'b0) $display("FAIL zw_next got %h valid %b exp 0003 0", mem_addr, instr_valid); else passed++;
    exp_pc = 16'h0003;
  endtask

  task automatic test_wait_states();
    int cyc; bit st, to; logic [23:0] ins; logic [15:0] ia;
    wcfg = '{0, 2, 0};
    mid_cnt = 0;
    acked.delete();
    run_instr(16'h0100, 0, cyc, st, to, ins, ia);
    total++; if (to || cyc != 5) $display("FAIL ws_cycles got %0d exp 5", cyc); else passed++;
    total++; if (mid_cnt != 3) $display("FAIL ws_hold got %0d exp 3", mid_cnt); else passed++;
    total++; if (ins !== exp_word(exp_pc) || ia !== exp_pc) $display("FAIL ws_instr got %h@%h exp %h@%h", ins, ia, exp_word(exp_pc), exp_pc); else passed++;
    exp_pc = 16'h0100;
  endtask

  task automatic test_multi_hold();
    int cyc; bit st, to; logic [23:0] ins; logic [15:0] ia;
    wcfg = '{0, 0, 0};
    run_instr(16'h1234, 3, cyc, st, to, ins, ia);
    total++; if (to || !st) $display("FAIL hold_stable got %b exp 1", st); else passed++;
    total++; if (ins !== exp_word(exp_pc) || ia !== exp_pc) $display("FAIL hold_instr got %h@%h exp %h@%h", ins, ia, exp_word(exp_pc), exp_pc); else passed++;
    total++; if (mem_addr !== 16'h1234 || mem_req !== 1'b1) $display("FAIL hold_next got %h req %b exp 1234 1", mem_addr, mem_req); else passed++;
    exp_pc = 16'h1234;
  endtask

  task automatic test_wrap();
    int cyc; bit st, to; logic [23:0] ins; logic [15:0] ia;
    run_instr(16'hFFFE, 0, cyc, st, to, ins, ia);
    total++; if (to || ins !== exp_word(exp_pc)) $display("FAIL pre_wrap got %h exp %h", ins, exp_word(exp_pc)); else passed++;
    exp_pc = 16'hFFFE;
    acked.delete();
    run_instr(16'h0200, 1, cyc, st, to, ins, ia);
    total++; if (acked.size() != 3 || acked[0] !== 16'hFFFE || acked[1] !== 16'hFFFF || acked[2] !== 16'h0000)
      $display("FAIL wrap_addr got %0d acks first %h exp FFFE FFFF 0000", acked.size(), acked.size() ? acked[0] : 16'hx); else passed++;
    total++; if (ins !== exp_word(16'hFFFE) || ia !== 16'hFFFE) $display("FAIL wrap_instr got %h@%h exp %h@FFFE", ins, ia, exp_word(16'hFFFE)); else passed++;
    exp_pc = 16'h0200;
  endtask

  task automatic test_halt();
    int n, bad, cyc; bit st, to; logic [23:0] ins; logic [15:0] ia;
    acked.delete();
    n = 0;
    while (acked.size() < 2 && n < 50) begin tick(); n++; end
    halt = 1;
    #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0202) $display("FAIL halt_f2 got %h req %b exp 0202 1", mem_addr, mem_req); else passed++;
    n = 0;
    while (!instr_valid && n < 50) begin tick(); n++; end
    total++; if (!instr_valid || instruction !== exp_word(16'h0200)) $display("FAIL halt_instr got %h exp %h", instruction, exp_word(16'h0200)); else passed++;
    fin = 1; next = 16'h0040;
    tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      fin = 1'($urandom % 2);
      tick();
      if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 16'h0040) bad++;
    end
    fin = 0;
    total++; if (bad != 0) $display("FAIL halt_idle got %0d bad cycles exp 0", bad); else passed++;
    halt = 0;
    #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) $display("FAIL halt_release got %h req %b exp 0040 1", mem_addr, mem_req); else passed++;
    run_instr(16'h0300, 0, cyc, st, to, ins, ia);
    total++; if (to || ins !== exp_word(16'h0040) || ia !== 16'h0040) $display("FAIL halt_resume got %h@%h exp %h@0040", ins, ia, exp_word(16'h0040)); else passed++;
    exp_pc = 16'h0300;
  endtask

  task automatic test_reset_mid();
    int n, cyc; bit st, to; logic [23:0] ins; logic [15:0] ia;
    acked.delete();
    n = 0;
    while (acked.size() < 1 && n < 50) begin tick(); n++; end
    rst = 1;
    tick();
    total++; if (instr_valid !== 1'b0 || instruction !== 24'h0) $display("FAIL rstmid_state got %b %h exp 0 000000", instr_valid, instruction); else passed++;
    total++; if (cia !== 16'h0 || mem_addr !== 16'h0 || mem_req !== 1'b0) $display("FAIL rstmid_pc got %h/%h req %b exp 0000 0", cia, mem_addr, mem_req); else passed++;
    rst = 0;
    waited = 0;
    acked.delete();
    run_instr(16'h0500, 0, cyc, st, to, ins, ia);
    total++; if (to || cyc != 3 || acked.size() != 3 || acked[0] !== 16'h0000) $display("FAIL rstmid_restart got %0d cycles exp 3 from 0000", cyc); else passed++;
    total++; if (ins !== exp_word(16'h0000) || ia !== 16'h0000) $display("FAIL rstmid_instr got %h@%h exp %h@0000", ins, ia, exp_word(16'h0000)); else passed++;
    exp_pc = 16'h0500;
  endtask

  task automatic test_random();
    int cyc, hold; bit st, to; logic [23:0] ins; logic [15:0] ia, nxt, p1, p2;
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 3; j++) wcfg[j] = $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      nxt = (k % 5 == 0) ? 16'hFFFD + 16'($urandom_range(0, 2)) : 16'($urandom);
      acked.delete();
      run_instr(nxt, hold, cyc, st, to, ins, ia);
      p1 = exp_pc + 16'd1;
      p2 = exp_pc + 16'd2;
      total++; if (to || cyc != 3 + wcfg[0] + wcfg[1] + wcfg[2]) $display("FAIL rnd%0d_cycles got %0d exp %0d", k, cyc, 3 + wcfg[0] + wcfg[1] + wcfg[2]); else passed++;
      total++; if (ins !== exp_word(exp_pc) || ia !== exp_pc) $display("FAIL rnd%0d_instr got %h@%h exp %h@%h", k, ins, ia, exp_word(exp_pc), exp_pc); else passed++;
      total++; if (acked.size() != 3 || acked[0] !== exp_pc || acked[1] !== p1 || acked[2] !== p2) $display("FAIL rnd%0d_addrs got %0d acks exp 3 from %h", k, acked.size(), exp_pc); else passed++;
      total++; if (!st) $display("FAIL rnd%0d_hold got unstable exp stable", k); else passed++;
      exp_pc = nxt;
    end
  endtask

  initial begin
    rst = 1; halt = 0; mem_ack = 0; mem_data = 0; fin = 0; next = 0;
    total = 0; passed = 0; waited = 0; mid_cnt = 0;
    wcfg = '{0, 0, 0};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_multi_hold();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
